// File: rtl/clean_beats_rom_loader.sv
// Boot-image loader: streams words into the on-chip ROM through its debug-write
// port, reads the same range back and compares additive checksums.
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | accepting stream words, one bus write per accepted word
// READ   | one read per cycle over the same address range
// DRAIN  | capturing the last read word
// FINISH | done pulse, checksum/error valid
module clean_beats_rom_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              debugaccess,
  output logic              clken,
  input  logic [DATA_W-1:0] readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;
  logic [DATA_W-1:0] rsum_nxt;
  logic              cap_vld;

  assign byteenable = 4'hF;
  assign clken      = 1'b1;

  // readdata belongs to the read issued on the previous cycle
  always_comb begin
    rsum_nxt = rsum;
    if (cap_vld) rsum_nxt = rsum + readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx         <= '0;
      wsum        <= '0;
      rsum        <= '0;
      cap_vld     <= 1'b0;
      in_ready    <= 1'b0;
      address     <= '0;
      chipselect  <= 1'b0;
      write       <= 1'b0;
      writedata   <= '0;
      debugaccess <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      checksum    <= '0;
    end else begin
      cap_vld <= chipselect && !write;
      rsum    <= rsum_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            idx      <= '0;
            wsum     <= '0;
            rsum     <= '0;
            error    <= 1'b0;
            checksum <= '0;
            if (length == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else if (length > MAX_LEN) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (in_ready) begin
            if (in_valid) begin
              chipselect  <= 1'b1;
              debugaccess <= 1'b1;
              write       <= 1'b1;
              address     <= base_q + idx[ADDR_W-1:0];
              writedata   <= in_data;
              wsum        <= wsum + in_data;
              idx         <= idx + ONE;
              if (idx + ONE == len_q) in_ready <= 1'b0;
            end else begin
              chipselect  <= 1'b0;
              debugaccess <= 1'b0;
              write       <= 1'b0;
            end
          end else begin
            // last write is on the bus now; issue the first read behind it
            chipselect  <= 1'b1;
            debugaccess <= 1'b1;
            write       <= 1'b0;
            address     <= base_q;
            idx         <= ONE;
            state       <= READ;
          end
        end
        READ: begin
          if (idx == len_q) begin
            chipselect  <= 1'b0;
            debugaccess <= 1'b0;
            state       <= DRAIN;
          end else begin
            chipselect  <= 1'b1;
            debugaccess <= 1'b1;
            address     <= base_q + idx[ADDR_W-1:0];
            idx         <= idx + ONE;
          end
        end
        DRAIN: begin
          done     <= 1'b1;
          checksum <= wsum;
          error    <= error | (wsum != rsum_nxt);
          state    <= FINISH;
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clean_beats_rom_loader.sv
// Bench for clean_beats_rom_loader: behavioural memory plus a cycle-level
// reference model of the load/verify transaction timeline.
module tb_clean_beats_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        debugaccess;
  logic        clken;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int errors = 0;
  int checks = 0;
  bit corrupt = 1'b0;
  logic [31:0] mem [0:1023];

  clean_beats_rom_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .debugaccess(debugaccess), .clken(clken),
    .readdata(readdata), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // ROM model: registered address, one-cycle read latency, optional bit flip at word 2
  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write)
      readdata <= mem[address] ^ ((corrupt && address == 10'd2) ? 32'd1 : 32'd0);
  end

  task automatic run_load(input logic [9:0] b, input int n, input int mode, input bit corr,
                          input int ignore_k, input bit seqdata, input string name);
    int k, acc, wcount, last_acc, end_cyc, cap;
    bit bad, exp_rdy, exp_cs, exp_wr, exp_busy, exp_done, acc_prev, acc_now, hit2, done_seen, fin;
    logic [31:0] dprev, sum;
    logic [9:0] exp_addr;
    logic exp_err;
    bad = (n == 0) || (n > 1024);
    corrupt = corr;
    acc = 0; wcount = 0; last_acc = -1; sum = 0; dprev = 0;
    acc_prev = 0; hit2 = 0; done_seen = 0; fin = 0;
    cap = bad ? 4 : 4 * n + 64;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = 11'(n); in_valid = 1'b1; in_data = $urandom;
    k = 0;
    while (!fin) begin
      @(posedge clk); #1;
      k++;
      start     = (k == ignore_k);
      base_addr = (k == ignore_k) ? ~b : b;
      length    = (k == ignore_k) ? 11'd3 : 11'(n);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (k % 2) == 1;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = seqdata ? 32'(acc + 1) : $urandom;
      exp_rdy = !bad && (acc < n);
      acc_now = exp_rdy && in_valid;
      exp_cs = 0; exp_wr = 0; exp_addr = '0;
      if (acc_prev) begin
        exp_cs = 1; exp_wr = 1; exp_addr = b + 10'(wcount);
        if (exp_addr == 10'd2) hit2 = 1;
      end else if (last_acc >= 0 && k >= last_acc + 2 && k <= last_acc + 1 + n) begin
        exp_cs = 1; exp_addr = b + 10'(k - last_acc - 2);
      end
      end_cyc  = bad ? 1 : ((last_acc >= 0) ? last_acc + n + 3 : -1);
      exp_done = (k == end_cyc);
      exp_busy = !bad && (end_cyc < 0 || k <= end_cyc);
      exp_err  = bad ? (n > 1024) : (corr && hit2);
      @(negedge clk);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL %s in_ready cyc %0d: got %b want %b", name, k, in_ready, exp_rdy);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL %s busy cyc %0d: got %b want %b", name, k, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL %s done cyc %0d: got %b want %b", name, k, done, exp_done);
      end
      checks++;
      if (chipselect !== exp_cs || debugaccess !== exp_cs) begin
        errors++; $display("FAIL %s chipselect/debugaccess cyc %0d: got %b/%b want %b",
                           name, k, chipselect, debugaccess, exp_cs);
      end
      if (exp_cs) begin
        checks++;
        if (write !== exp_wr || address !== exp_addr) begin
          errors++; $display("FAIL %s bus cyc %0d: got write=%b addr=%0d want write=%b addr=%0d",
                             name, k, write, address, exp_wr, exp_addr);
        end
      end
      if (exp_wr) begin
        checks++;
        if (writedata !== dprev) begin
          errors++; $display("FAIL %s writedata cyc %0d: got %h want %h", name, k, writedata, dprev);
        end
      end
      if (done === 1'b1) done_seen = 1;
      if (exp_done) begin
        checks++;
        if (checksum !== (bad ? 32'd0 : sum)) begin
          errors++; $display("FAIL %s checksum: got %h want %h", name, checksum, bad ? 32'd0 : sum);
        end
        checks++;
        if (error !== exp_err) begin
          errors++; $display("FAIL %s error: got %b want %b", name, error, exp_err);
        end
      end
      if (acc_prev) wcount++;
      if (acc_now) begin
        acc++; sum += in_data; dprev = in_data;
        if (acc == n) last_acc = k;
      end
      acc_prev = acc_now;
      if (end_cyc >= 0 && k >= end_cyc + 1) fin = 1;
      else if (k >= cap) fin = 1;
    end
    checks++;
    if (!done_seen || k >= cap) begin
      errors++; $display("FAIL %s completion: done_seen=%b cycles=%0d limit=%0d", name, done_seen, k, cap);
    end
    checks++;
    if (byteenable !== 4'hF || clken !== 1'b1) begin
      errors++; $display("FAIL %s constants: got be=%h clken=%b want F/1", name, byteenable, clken);
    end
    start = 0; in_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, chipselect, write, debugaccess, busy, done, error} !== 7'b0) begin
      errors++; $display("FAIL reset flags: got %b want 0", {in_ready, chipselect, write, debugaccess, busy, done, error});
    end
    checks++;
    if (address !== 10'd0 || writedata !== 32'd0 || checksum !== 32'd0) begin
      errors++; $display("FAIL reset data: got addr=%0d wd=%h cs=%h want 0", address, writedata, checksum);
    end
    checks++;
    if (byteenable !== 4'hF || clken !== 1'b1) begin
      errors++; $display("FAIL reset constants: got be=%h clken=%b want F/1", byteenable, clken);
    end
  endtask

  task automatic test_basic();
    run_load(10'd0, 4, 0, 0, -1, 1, "basic");
    checks++;
    if (checksum !== 32'h0000000A) begin
      errors++; $display("FAIL basic held checksum: got %h want 0000000a", checksum);
    end
  endtask

  task automatic test_wrap_backpressure();
    run_load(10'd1022, 4, 1, 0, -1, 0, "wrap_bp");
    run_load(10'd1020, 8, 0, 0, -1, 0, "wrap8");
  endtask

  task automatic test_corruption();
    run_load(10'd0, 8, 0, 1, -1, 0, "corrupt");
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL corrupt held error: got %b want 1", error);
    end
  endtask

  task automatic test_length_edges();
    run_load(10'd5, 0, 0, 0, -1, 0, "len0");
    run_load(10'd5, 1025, 0, 0, -1, 0, "len1025");
    run_load(10'd300, 1024, 0, 0, -1, 0, "len1024");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1; base_addr = 10'd100; length = 11'd8; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 0; in_data = $urandom;
    end
    reset = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, chipselect, write, debugaccess, busy, done, error} !== 7'b0) begin
      errors++; $display("FAIL reset_mid flags: got %b want 0", {in_ready, chipselect, write, debugaccess, busy, done, error});
    end
    checks++;
    if (address !== 10'd0 || writedata !== 32'd0 || checksum !== 32'd0) begin
      errors++; $display("FAIL reset_mid data: got addr=%0d wd=%h cs=%h want 0", address, writedata, checksum);
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_mid quiet: got done=%b busy=%b want 0/0", done, busy);
      end
    end
    run_load(10'd100, 8, 0, 0, -1, 0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    run_load(10'd40, 6, 0, 0, 3, 0, "start_busy");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      run_load(10'($urandom_range(0, 1023)), int'($urandom_range(1, 16)), 2, 0, -1, 0, "random");
  endtask

  initial begin
    reset = 1; start = 0; base_addr = '0; length = '0; in_data = '0; in_valid = 0;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    reset = 0;
    test_basic();
    test_wrap_backpressure();
    test_corruption();
    test_length_edges();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
